// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  muldiv_unit : iterative RV32M multiply/divide, 32 shift-add / restoring
//                iterations, start/busy/done handshake, register-file write.
//  Revision    : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      dest_reg,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] write_data,
    output logic [4:0]      write_reg,
    output logic            write_en
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   a_orig;
    logic              res_neg;
    logic              rem_neg;
    logic              div_zero;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quot, remd, result;

    assign accept   = (state == IDLE) && start;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign write_en = done && (write_reg != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand conditioning at accept: magnitudes plus the sign/special flags.
    always_comb begin
        a_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && operand_a[XLEN-1];
        b_neg    = b_signed && operand_b[XLEN-1];
        mag_a    = a_neg ? (~operand_a + 1'b1) : operand_a;
        mag_b    = b_neg ? (~operand_b + 1'b1) : operand_b;
    end

    // One iteration step; the final result is formed from the last step's
    // output so that write_data lands on the same edge DONE is entered.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!op[2])
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

        prod = res_neg ? (~acc_next + 1'b1) : acc_next;
        if (div_zero)
            quot = '1;
        else
            quot = res_neg ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
        if (div_zero)
            remd = a_orig;
        else
            remd = rem_neg ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];

        case (op)
            3'b000:                 result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quot;
            default:                result = remd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            op         <= 3'b000;
            acc        <= '0;
            opnd       <= '0;
            a_orig     <= '0;
            res_neg    <= 1'b0;
            rem_neg    <= 1'b0;
            div_zero   <= 1'b0;
            write_data <= '0;
            write_reg  <= 5'd0;
        end else if (accept) begin
            count     <= '0;
            op        <= funct3;
            a_orig    <= operand_a;
            res_neg   <= a_neg ^ b_neg;
            rem_neg   <= a_neg;
            div_zero  <= funct3[2] && (operand_b == '0);
            write_reg <= dest_reg;
            if (funct3[2]) begin
                acc  <= {{XLEN{1'b0}}, mag_a};
                opnd <= mag_b;
            end else begin
                acc  <= {{XLEN{1'b0}}, mag_b};
                opnd <= mag_a;
            end
        end else if (state == CALC) begin
            count <= count + 1'b1;
            acc   <= acc_next;
            if (count == LAST)
                write_data <= result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  tb_muldiv_unit : directed self-checking bench for muldiv_unit.
//  Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  dest_reg = 5'd0;
    logic        busy, done, write_en;
    logic [31:0] write_data;
    logic [4:0]  write_reg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct3     (funct3),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_reg   (dest_reg),
        .busy       (busy),
        .done       (done),
        .write_data (write_data),
        .write_reg  (write_reg),
        .write_en   (write_en)
    );

    // Issues one operation, optionally pulsing start again at cycles p1/p2
    // after acceptance, and records what the unit did over 34 cycles.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int p1, input int p2,
                          output int lat, output int ndone, output int nwe,
                          output logic [31:0] wd, output logic [4:0] wr,
                          output logic b1, output logic b33);
        lat = 0; ndone = 0; nwe = 0; wd = '0; wr = '0; b1 = 1'b0; b33 = 1'b1;
        @(negedge clk);
        start = 1'b1; funct3 = f; operand_a = a; operand_b = b; dest_reg = rd;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        dest_reg = 5'($urandom);
        for (int k = 1; k <= 34; k++) begin
            if (k == p1 || k == p2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 1)  b1  = busy;
            if (k == 33) b33 = busy;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k; wd = write_data; wr = write_reg;
                end
            end
            if (write_en) nwe++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got %b exp 0", done); end
        total++; if (write_en !== 1'b0)   begin bad++; $display("FAIL reset_we got %b exp 0", write_en); end
        total++; if (write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got %h exp 0", write_data); end
        total++; if (write_reg !== 5'd0)  begin bad++; $display("FAIL reset_wreg got %0d exp 0", write_reg); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        int lat, nd, nwe; logic [31:0] wd; logic [4:0] wr; logic b1, b33;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 0, lat, nd, nwe, wd, wr, b1, b33);
        total++; if (lat !== 32)           begin bad++; $display("FAIL mul_latency got %0d exp 32", lat); end
        total++; if (wd !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_data got %h exp ffffffeb", wd); end
        total++; if (wr !== 5'd5)          begin bad++; $display("FAIL mul_wreg got %0d exp 5", wr); end
        total++; if (nwe !== 1)            begin bad++; $display("FAIL mul_we_count got %0d exp 1", nwe); end
        total++; if (nd !== 1)             begin bad++; $display("FAIL mul_done_count got %0d exp 1", nd); end
        total++; if (b1 !== 1'b1)          begin bad++; $display("FAIL mul_busy_rise got %b exp 1", b1); end
        total++; if (b33 !== 1'b0)         begin bad++; $display("FAIL mul_busy_fall got %b exp 0", b33); end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_arith();
        vec_t v[13];
        int lat, nd, nwe; logic [31:0] wd; logic [4:0] wr; logic b1, b33;
        v[0]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[3]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        v[4]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        v[5]  = '{3'b101, 32'd100,       32'd7,         32'd14};
        v[6]  = '{3'b111, 32'd100,       32'd7,         32'd2};
        v[7]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[8]  = '{3'b111, 32'd5,         32'd0,         32'd5};
        v[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        v[11] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[12] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, 5'(i + 1), 0, 0, lat, nd, nwe, wd, wr, b1, b33);
            total++;
            if (lat !== 32) begin
                bad++; $display("FAIL arith%0d_latency got %0d exp 32", i, lat);
            end
            total++;
            if (wd !== v[i].exp) begin
                bad++; $display("FAIL arith%0d_data f3=%b got %h exp %h", i, v[i].f, wd, v[i].exp);
            end
            total++;
            if (wr !== 5'(i + 1)) begin
                bad++; $display("FAIL arith%0d_wreg got %0d exp %0d", i, wr, i + 1);
            end
        end
    endtask

    task automatic test_handshake();
        int lat, nd, nwe; logic [31:0] wd; logic [4:0] wr; logic b1, b33;
        run_op(3'b000, 32'd3, 32'd4, 5'd9, 5, 32, lat, nd, nwe, wd, wr, b1, b33);
        total++; if (nd !== 1)     begin bad++; $display("FAIL hs_done_count got %0d exp 1", nd); end
        total++; if (lat !== 32)   begin bad++; $display("FAIL hs_latency got %0d exp 32", lat); end
        total++; if (wd !== 32'd12) begin bad++; $display("FAIL hs_data got %h exp 0000000c", wd); end
        total++; if (b33 !== 1'b0) begin bad++; $display("FAIL hs_idle_after got %b exp 0", b33); end
    endtask

    task automatic test_rd_zero();
        int lat, nd, nwe; logic [31:0] wd; logic [4:0] wr; logic b1, b33;
        run_op(3'b101, 32'd100, 32'd7, 5'd0, 0, 0, lat, nd, nwe, wd, wr, b1, b33);
        total++; if (nd !== 1)      begin bad++; $display("FAIL rd0_done_count got %0d exp 1", nd); end
        total++; if (nwe !== 0)     begin bad++; $display("FAIL rd0_we_count got %0d exp 0", nwe); end
        total++; if (wd !== 32'd14) begin bad++; $display("FAIL rd0_data got %h exp 0000000e", wd); end
    endtask

    task automatic test_reset_mid();
        int lat, nd, nwe; logic [31:0] wd; logic [4:0] wr; logic b1, b33;
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
        dest_reg = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        total++; if (write_data !== 32'h0) begin bad++; $display("FAIL rstmid_wdata got %h exp 0", write_data); end
        total++; if (write_reg !== 5'd0)   begin bad++; $display("FAIL rstmid_wreg got %0d exp 0", write_reg); end
        for (int k = 0; k < 30; k++) begin
            if (k == 2) begin
                @(negedge clk); reset = 1'b0;
            end
            @(posedge clk); #1;
            if (done || write_en) seen_done++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL rstmid_no_done got %0d exp 0", seen_done); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0, lat, nd, nwe, wd, wr, b1, b33);
        total++; if (lat !== 32)           begin bad++; $display("FAIL rstmid_latency got %0d exp 32", lat); end
        total++; if (wd !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rstmid_data got %h exp fffffffe", wd); end
        total++; if (nwe !== 1)            begin bad++; $display("FAIL rstmid_we_count got %0d exp 1", nwe); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_arith();
        test_handshake();
        test_rd_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the simple RISC-V CPU.

- **Upstream:** takes the two source operands read from the register file, plus the decoded funct3 and destination register.
- **Datapath:** computes the result over a fixed 32-iteration shift-add / restoring-divide loop.
- **Downstream:** drives the register file write port (`write_reg`, `write_data`, `write_en`) for exactly one cycle on completion.
- **Control:** a start/busy/done handshake lets the control unit stall the pipeline while the unit works.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  32  rs1 value (`data_out_1` of the register file).
- `operand_b`  in  32  rs2 value (`data_out_2` of the register file).
- `dest_reg`  in  5  rd index.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle completion pulse.
- `write_data`  out  32  result; held until the next accepted start.
- `write_reg`  out  5  rd captured at start.
- `write_en`  out  1  `done && write_reg != 0`.

## Operation
- **FSM states:**
  - IDLE: on `start`, go to CALC.
  - CALC: go to DONE when the iteration counter reaches 31.
  - DONE: always go to IDLE after one cycle.
- **Capture on the start edge:** `funct3`, `dest_reg`, operand magnitudes, result-sign flag, and the special-case flags (div-by-zero).
- **Operand signedness:**
  - Signed: MUL/MULH/DIV/REM use both operands signed.
  - MULHSU: a is signed, b is unsigned.
  - Unsigned: MULHU/DIVU/REMU.
  - MUL low word is sign-independent.
- **Multiply:**
  - 64-bit accumulator; one shift-add per CALC cycle on the magnitudes.
  - Two's-complement negate the 64-bit product if the result sign is negative.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- **Divide (restoring):**
  - One quotient bit per CALC cycle on the magnitudes.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- **Division special cases** (fixed by the ISA, applied at DONE):
  - Divisor 0: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = `operand_a` unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; the normal datapath already produces this, with no override.
- **Sign-fix arithmetic:** all sign fixing is 32/64-bit wrap-around two's complement; no saturation.

## Timing
- **Reset values:** `busy`=0, `done`=0, `write_en`=0, `write_data`=0, `write_reg`=0, state IDLE, counter 0.
- **Fixed latency, all funct3 and special cases:**
  - `start` is sampled high in IDLE at edge N.
  - CALC iterations occupy edges N+1..N+32.
  - DONE is entered at edge N+32; `done` and `write_en` are high during cycle N+32 to N+33.
  - IDLE resumes at edge N+33.
- **Busy window:** `busy` rises after edge N and falls after edge N+33.
- **Start handling:**
  - `start` is ignored in CALC and DONE; inputs may change freely after edge N.
  - Back-to-back: earliest next accept is edge N+33 (start held high in IDLE); interval 33 cycles.
- **Result visibility:** `write_data` and `write_reg` are valid from edge N+32 and stable until the next accepted start.
- **Write suppression:** `dest_reg`=0 means `write_en` never asserts; `done` still pulses.
- **Reset mid-operation:** immediate return to reset values; no `done` or `write_en` pulse; the next start is accepted normally.
- **Register file write:** the file writes combinationally; `write_en` is exactly one cycle, so no double write.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=5 -> `done` exactly 32 cycles after the start edge; `write_data`=0xFFFFFFEB, `write_reg`=5, `write_en` one cycle.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU -> 2.
- Edge-case divides:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM -> 0.
- Handshake:
  - `start` pulsed again at cycles 5 and 32 after acceptance -> ignored; one `done` only.
  - `dest_reg`=0 -> `done` pulses, `write_en` stays 0.
- Async reset asserted mid-CALC (cycle 10) -> outputs zero immediately, no `done`; fresh MULHU after release completes correctly in 32 cycles.
